// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream handshake plus instruction-memory write port
interface prog_loader_if #(
    parameter int ADDR_W = 5
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              IM_WR;
    logic [ADDR_W-1:0] IM_DIR;
    logic [31:0]       IM_DI;

    // Byte source and memory observer side
    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  IM_WR,
        input  IM_DIR,
        input  IM_DI
    );

    // Loader side
    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output IM_WR,
        output IM_DIR,
        output IM_DI
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: assembles a byte stream into 32-bit words, writes them to
// instruction memory and holds the core in reset until the load completes.
module prog_loader #(
    parameter int ADDR_W     = 5,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic            reloj,
    input  logic            reset_n,
    input  logic            start,
    input  logic [ADDR_W:0] len_words,
    prog_loader_if.slave    bus,
    output logic            cpu_reset,
    output logic            busy,
    output logic            done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_wordAddr;
    logic [1:0]        r_byteCnt;
    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_imDir;
    logic [31:0]       r_imDi;

    logic              w_xfer;
    logic              w_lastWord;
    logic [ADDR_W:0]   w_lenClamped;
    logic [31:0]       w_nextWord;

    // Handshake, length clamp, last-word detect and byte-shift of the partial word
    always_comb begin
        w_xfer       = bus.byte_valid && (r_state == S_RECV);
        w_lenClamped = (len_words > CAPACITY) ? CAPACITY : len_words;
        w_lastWord   = ({1'b0, r_wordAddr} == (r_len - LEN_ONE));
        if (BIG_ENDIAN)
            w_nextWord = {r_word[23:0], bus.byte_data};
        else
            w_nextWord = {bus.byte_data, r_word[31:8]};
    end

    // Load sequencer; the write port registers are captured on the 4th byte so they hold outside WRITE
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_wordAddr <= '0;
            r_byteCnt  <= '0;
            r_word     <= '0;
            r_imDir    <= '0;
            r_imDi     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (len_words == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state    <= S_RECV;
                            r_len      <= w_lenClamped;
                            r_wordAddr <= '0;
                            r_byteCnt  <= '0;
                            r_word     <= '0;
                        end
                    end
                end
                S_RECV: begin
                    if (w_xfer) begin
                        r_word    <= w_nextWord;
                        r_byteCnt <= r_byteCnt + 2'd1;
                        if (r_byteCnt == 2'd3) begin
                            r_state <= S_WRITE;
                            r_imDir <= r_wordAddr;
                            r_imDi  <= w_nextWord;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_lastWord) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state    <= S_RECV;
                        r_wordAddr <= r_wordAddr + ADDR_ONE;
                        r_byteCnt  <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = (r_state == S_RECV);
    assign bus.IM_WR      = (r_state == S_WRITE);
    assign bus.IM_DIR     = r_imDir;
    assign bus.IM_DI      = r_imDi;
    assign busy           = (r_state == S_RECV) || (r_state == S_WRITE);
    assign done           = (r_state == S_DONE);
    assign cpu_reset      = (r_state != S_DONE);
endmodule
